// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the asynchronous instruction
// ROM and captures the returned word with its PC into the IF/ID register.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   stall[5:0]       controller stall vector (bit0 PC, bit1 IF, bit2 ID)
//   flush, new_pc    exception redirect; clears IF/ID
//   branch_flag_i,   taken branch/jump resolved in ID, and its target
//   branch_target_i
//   rom_ce, rom_addr ROM chip enable and byte address (both registered)
//   rom_inst         combinational ROM read data
//   id_pc, id_inst,  IF/ID register contents presented to decode
//   id_valid
module if_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_valid
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] new_pc_aligned;
    logic [ADDR_W-1:0] branch_target_aligned;

    // Higher stall bits belong to later stages; low address bits are forced to zero.
    logic unused_bits;
    assign unused_bits = ^{stall[5:3], new_pc[1:0], branch_target_i[1:0]};

    assign new_pc_aligned        = {new_pc[ADDR_W-1:2], 2'b00};
    assign branch_target_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign rom_addr              = pc;

    // Next-PC selection; flush beats stall, and a stalled PC ignores the branch
    // because ID is stalled too and will present it again.
    always_comb begin
        pc_next = pc;
        if (!rom_ce) begin
            pc_next = RESET_PC;
        end else if (flush) begin
            pc_next = new_pc_aligned;
        end else if (stall[0]) begin
            pc_next = pc;
        end else if (branch_flag_i) begin
            pc_next = branch_target_aligned;
        end else begin
            pc_next = pc + ADDR_W'(4);
        end
    end

    // PC register and ROM enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_ce <= 1'b0;
            pc     <= RESET_PC;
        end else begin
            rom_ce <= 1'b1;
            pc     <= pc_next;
        end
    end

    // IF/ID pipeline register: flush and IF-only stalls insert a NOP bubble,
    // a stall that also covers ID holds the current contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else if (flush || (stall[1] && !stall[2])) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
        end else if (!stall[1]) begin
            id_pc    <= pc;
            id_inst  <= rom_inst;
            id_valid <= rom_ce;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a transaction-level fetch model checked
// every cycle, plus directed scenarios with hand-computed expected values.
module tb_if_stage;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              id_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .new_pc         (new_pc),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_valid       (id_valid)
    );

    always #5 clk = ~clk;

    // ROM contents: word N holds 0x1000_0000 + N.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: what the fetch unit is presenting and what decode holds.
    bit          m_live = 1'b0;
    bit          m_fetching;
    logic [31:0] m_fetch_addr;
    logic [31:0] m_dec_pc;
    logic [31:0] m_dec_inst;
    bit          m_dec_real;

    always @(posedge clk) begin
        logic [31:0] word_now;
        logic [31:0] addr_now;
        bit          fetching_now;
        if (rst) begin
            m_live       = 1'b1;
            m_fetching   = 1'b0;
            m_fetch_addr = 32'h0;
            m_dec_pc     = 32'h0;
            m_dec_inst   = 32'h0;
            m_dec_real   = 1'b0;
        end else begin
            addr_now     = m_fetch_addr;
            fetching_now = m_fetching;
            word_now     = fetching_now ? rom_word(addr_now) : 32'h0;

            // Decode side: flush or an IF-only stall yields a NOP bubble.
            if (flush || (stall[1] && !stall[2])) begin
                m_dec_pc   = 32'h0;
                m_dec_inst = 32'h0;
                m_dec_real = 1'b0;
            end else if (!stall[1]) begin
                m_dec_pc   = addr_now;
                m_dec_inst = word_now;
                m_dec_real = fetching_now;
            end

            // Fetch side: first fetch is the reset vector, then redirects or sequential.
            if (!fetching_now)            m_fetch_addr = 32'h0;
            else if (flush)               m_fetch_addr = new_pc & ~32'h3;
            else if (stall[0])            m_fetch_addr = addr_now;
            else if (branch_flag_i)       m_fetch_addr = branch_target_i & ~32'h3;
            else                          m_fetch_addr = addr_now + 32'd4;
            m_fetching = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            chk("rom_ce",   {31'h0, rom_ce},   {31'h0, m_fetching});
            chk("rom_addr", rom_addr,          m_fetch_addr);
            chk("id_pc",    id_pc,             m_dec_pc);
            chk("id_inst",  id_inst,           m_dec_inst);
            chk("id_valid", {31'h0, id_valid}, {31'h0, m_dec_real});
        end
    end

    task automatic idle_inputs();
        stall           = 6'b0;
        flush           = 1'b0;
        new_pc          = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // 1. Reset, then sequential fetch.
        cyc(2);
        chk("lit_reset_ce",    {31'h0, rom_ce}, 32'h0);
        chk("lit_reset_addr",  rom_addr,        32'h0);
        chk("lit_reset_inst",  id_inst,         32'h0);
        rst = 1'b0;
        cyc(1);
        chk("lit_ce_rise",     {31'h0, rom_ce}, 32'h1);
        chk("lit_first_addr",  rom_addr,        32'h0);
        cyc(1);
        chk("lit_addr_4",      rom_addr,        32'h4);
        chk("lit_inst_0",      id_inst,         32'h1000_0000);
        chk("lit_valid_0",     {31'h0, id_valid}, 32'h1);
        cyc(1);
        chk("lit_addr_8",      rom_addr,        32'h8);
        chk("lit_inst_1",      id_inst,         32'h1000_0001);
        chk("lit_idpc_4",      id_pc,           32'h4);

        // 2. Branch to 0x40 while pc=0x8: delay slot 0x8, then 0x40, 0x44.
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        cyc(1);
        idle_inputs();
        chk("lit_delay_slot",  id_pc,           32'h8);
        chk("lit_br_addr",     rom_addr,        32'h40);
        cyc(1);
        chk("lit_br_target",   id_pc,           32'h40);
        chk("lit_br_inst",     id_inst,         32'h1000_0010);
        cyc(1);
        chk("lit_br_next",     id_pc,           32'h44);

        // 3. Get to pc=0x10, then stall PC+IF for three cycles.
        branch_flag_i = 1'b1; branch_target_i = 32'h10;
        cyc(1);
        idle_inputs();
        chk("lit_pc_10",       rom_addr,        32'h10);
        stall = 6'b000011;
        cyc(3);
        chk("lit_stall_pc",    rom_addr,        32'h10);
        chk("lit_bubble_inst", id_inst,         32'h0);
        chk("lit_bubble_val",  {31'h0, id_valid}, 32'h0);
        stall = 6'b0;
        cyc(1);
        chk("lit_unstall_pc",  id_pc,           32'h10);
        chk("lit_unstall_in",  id_inst,         32'h1000_0004);
        // Stall also covering ID holds decode contents.
        stall = 6'b000111;
        cyc(3);
        chk("lit_hold_pc",     id_pc,           32'h10);
        chk("lit_hold_inst",   id_inst,         32'h1000_0004);
        chk("lit_hold_valid",  {31'h0, id_valid}, 32'h1);
        chk("lit_hold_fetch",  rom_addr,        32'h14);
        stall = 6'b0;
        cyc(1);
        chk("lit_hold_rel",    id_pc,           32'h14);

        // 4. Flush beats stall and branch.
        flush = 1'b1; new_pc = 32'h20; stall = 6'b000011;
        branch_flag_i = 1'b1; branch_target_i = 32'h80;
        cyc(1);
        idle_inputs();
        chk("lit_flush_pc",    rom_addr,        32'h20);
        chk("lit_flush_valid", {31'h0, id_valid}, 32'h0);
        cyc(1);
        chk("lit_flush_fetch", id_pc,           32'h20);
        chk("lit_flush_inst",  id_inst,         32'h1000_0008);

        // Stalled PC ignores a branch presented alongside it.
        stall = 6'b000111; branch_flag_i = 1'b1; branch_target_i = 32'h200;
        cyc(2);
        idle_inputs();
        chk("lit_stall_br",    rom_addr,        32'h24);
        cyc(1);

        // 5. Alignment and wrap.
        branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
        cyc(1);
        idle_inputs();
        chk("lit_align_top",   rom_addr,        32'hFFFF_FFFC);
        cyc(1);
        chk("lit_wrap",        rom_addr,        32'h0);
        chk("lit_wrap_idpc",   id_pc,           32'hFFFF_FFFC);
        chk("lit_wrap_inst",   id_inst,         32'h4FFF_FFFF);
        flush = 1'b1; new_pc = 32'h33;
        cyc(1);
        idle_inputs();
        chk("lit_flush_align", rom_addr,        32'h30);
        cyc(2);

        // 6. Reset in the same cycle as a branch.
        rst = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        cyc(1);
        chk("lit_rst_ce",      {31'h0, rom_ce}, 32'h0);
        chk("lit_rst_addr",    rom_addr,        32'h0);
        chk("lit_rst_idpc",    id_pc,           32'h0);
        chk("lit_rst_valid",   {31'h0, id_valid}, 32'h0);
        rst = 1'b0;
        idle_inputs();
        cyc(1);
        chk("lit_restart",     rom_addr,        32'h0);
        cyc(1);
        chk("lit_restart_4",   rom_addr,        32'h4);
        chk("lit_restart_in",  id_inst,         32'h1000_0000);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
